debounce_botones: RTL and testbench
===================================

Name: debounce_botones

Overview:
- Upstream conditioning stage for the operand/opcode loader; sits between the board push-buttons and the loader's boton_a / boton_b / boton_op inputs.
- Each raw, bouncing, asynchronous button is synchronised, debounced with a per-channel counter, and turned into a clean single-cycle press pulse.
- One press therefore loads the loader's A, B or OP register exactly once.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range 2 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 20, width of each channel's debounce counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- boton_a_in  input  1  raw push-button for operand A; asynchronous, bouncing.
- boton_b_in  input  1  raw push-button for operand B; asynchronous, bouncing.
- boton_op_in  input  1  raw push-button for the opcode; asynchronous, bouncing.
- boton_a  output  1  one-cycle press pulse for A; drives the loader's boton_a.
- boton_b  output  1  one-cycle press pulse for B; drives the loader's boton_b.
- boton_op  output  1  one-cycle press pulse for OP; drives the loader's boton_op.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Three identical, fully independent channels (A, B, OP). Per-channel state:
  - sync1, sync2: 2-FF synchroniser.
  - estable: accepted level.
  - cnt[CNT_WIDTH-1:0]: debounce counter.
  - pulso: registered output.
- Reset (reset=1 at an edge): sync1, sync2, estable, cnt and pulso all go to 0; all outputs are 0 in the following cycle. Reset takes priority over any operation in progress.
- Synchroniser: each edge, sync1 <= raw and sync2 <= sync1. No other logic samples raw.
- Channel FSM, with the state equal to estable:
  - SUELTO (estable=0):
    - If sync2=1, cnt increments.
    - If sync2=0, cnt clears to 0.
    - When sync2=1 and cnt=DEBOUNCE_CYCLES-1 at an edge: estable <= 1, cnt <= 0, pulso <= 1, next state PRESIONADO.
  - PRESIONADO (estable=1):
    - Same counting, but against sync2=0.
    - On acceptance: estable <= 0, cnt <= 0, no pulse, next state SUELTO.
- pulso is forced to 0 on every edge that is not an acceptance into PRESIONADO. It is never high for two consecutive cycles.
- Latency: raw first sampled high at edge k and held clean gives pulso high exactly during the cycle after edge k+1+DEBOUNCE_CYCLES.
- Bounce: any glitch of sync2 back to the estable level clears cnt. Acceptance needs DEBOUNCE_CYCLES uninterrupted cycles.
- Held button: only one pulse, however long it is held. A new pulse needs a debounced release and then a debounced press.
- Button held across reset release: treated as a fresh press, so one pulse after the normal latency.
- Simultaneous presses on several channels: pulses may coincide. Arbitration is the loader's job (A > B > OP).
- Counter never wraps: it clears on acceptance before reaching 2^CNT_WIDTH.

Decomposition:
- Shared package/header constants:
  - Default DEBOUNCE_CYCLES and CNT_WIDTH.
  - Simulation value DEBOUNCE_SIM = 4.
  - State encodings SUELTO=1'b0, PRESIONADO=1'b1.
- Natural sub-module: debounce_canal. It holds one channel (synchroniser, counter, FSM, pulse) with ports clk, reset, raw_in, pulso_out. The top instantiates it three times and adds no other logic.

Test Plan (DEBOUNCE_CYCLES=4, CNT_WIDTH=3):
- Reset: hold reset 3 cycles with all raw inputs 1 -> all outputs 0 during reset. After release, exactly one pulse per channel, 6 cycles after the first sampling edge.
- Clean press: boton_a_in 0->1 sampled at edge 10, held 50 cycles -> boton_a=1 only in the cycle after edge 15. boton_b and boton_op stay 0 throughout.
- Bounce: boton_b_in toggles 1,0,1,0,1 on successive edges, then stays 1 -> no pulse during toggling. A single pulse comes 6 cycles after the final rise is sampled.
- Short glitch: boton_op_in high for 3 cycles, then low -> no pulse, and cnt returns to 0.
- Re-press: press A, release for 10 cycles, press again -> exactly two boton_a pulses. A release lasting only 3 cycles between presses -> exactly one pulse.
- Mid-debounce reset: reset asserted while cnt=2 on channel A -> cnt=0, no pulse. Counting restarts from 0 after reset deasserts.

Source files
------------

// File: rtl/debounce_botones_pkg.sv
// Shared constants and state encoding for the push-button debounce stage.
// Imported by the per-channel debouncer and by the three-channel top.
package debounce_botones_pkg;

  localparam int DEBOUNCE_DEFAULT  = 1000000;
  localparam int CNT_WIDTH_DEFAULT = 20;
  localparam int DEBOUNCE_SIM      = 4;

  // The channel state is the accepted (debounced) button level.
  typedef enum logic {
    SUELTO     = 1'b0,
    PRESIONADO = 1'b1
  } estado_t;

  // True when the synchronised input disagrees with the accepted level.
  function automatic logic contra_estable(input estado_t estado, input logic nivel);
    return (nivel != logic'(estado));
  endfunction

endpackage

// File: rtl/debounce_canal.sv
// One button channel: 2-FF synchroniser, stability counter and press FSM.
// Emits a single-cycle pulse when a debounced press is accepted.
module debounce_canal
  import debounce_botones_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic pulso_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_FIN = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_UNO = CNT_WIDTH'(1);

  logic                 sync1_r;
  logic                 sync2_r;
  estado_t              estado_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 pulso_r;

  // Synchroniser, counter and FSM; only an accepted press raises the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      estado_r <= SUELTO;
      cnt_r    <= '0;
      pulso_r  <= 1'b0;
    end else begin
      sync1_r <= raw_in;
      sync2_r <= sync1_r;
      pulso_r <= 1'b0;
      case (estado_r)
        SUELTO: begin
          if (contra_estable(estado_r, sync2_r)) begin
            if (cnt_r == CNT_FIN) begin
              estado_r <= PRESIONADO;
              cnt_r    <= '0;
              pulso_r  <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_UNO;
            end
          end else begin
            cnt_r <= '0;
          end
        end
        PRESIONADO: begin
          if (contra_estable(estado_r, sync2_r)) begin
            if (cnt_r == CNT_FIN) begin
              estado_r <= SUELTO;
              cnt_r    <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_UNO;
            end
          end else begin
            cnt_r <= '0;
          end
        end
        default: begin
          estado_r <= SUELTO;
          cnt_r    <= '0;
        end
      endcase
    end
  end

  assign pulso_out = pulso_r;

endmodule

// File: rtl/debounce_botones.sv
// Three independent debounced press-pulse channels feeding the loader's
// boton_a / boton_b / boton_op inputs; coincident pulses are left to the loader.
module debounce_botones
  import debounce_botones_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_a_in,
  input  logic boton_b_in,
  input  logic boton_op_in,
  output logic boton_a,
  output logic boton_b,
  output logic boton_op
);

  debounce_canal #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_canal_a (
    .clk      (clk),
    .reset    (reset),
    .raw_in   (boton_a_in),
    .pulso_out(boton_a)
  );

  debounce_canal #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_canal_b (
    .clk      (clk),
    .reset    (reset),
    .raw_in   (boton_b_in),
    .pulso_out(boton_b)
  );

  debounce_canal #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_canal_op (
    .clk      (clk),
    .reset    (reset),
    .raw_in   (boton_op_in),
    .pulso_out(boton_op)
  );

endmodule

// File: tb/tb_debounce_botones.sv
// Scoreboard bench for debounce_botones: stimulus pushes the edge number at
// which each press pulse must appear; a negedge monitor pops and compares.
module tb_debounce_botones;
  import debounce_botones_pkg::*;

  localparam int CW = 3;
  // First sampling edge k gives a pulse visible after edge k+1+D; inputs are
  // driven at the negedge following edge n, so k = n+1.
  localparam int LAT = DEBOUNCE_SIM + 2;

  logic clk = 1'b0;
  logic reset;
  logic boton_a_in, boton_b_in, boton_op_in;
  logic boton_a, boton_b, boton_op;

  int edge_n    = 0;
  int n_checks  = 0;
  int n_fail    = 0;
  logic rst_edge = 1'b0;
  logic [2:0] outs;
  logic [2:0] prev_outs = 3'b000;
  int qa[$];
  int qb[$];
  int qo[$];

  debounce_botones #(
    .DEBOUNCE_CYCLES(DEBOUNCE_SIM),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .boton_a_in (boton_a_in),
    .boton_b_in (boton_b_in),
    .boton_op_in(boton_op_in),
    .boton_a    (boton_a),
    .boton_b    (boton_b),
    .boton_op   (boton_op)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_n   <= edge_n + 1;
    rst_edge <= reset;
  end

  function automatic int q_size(input int c);
    case (c)
      0:       return qa.size();
      1:       return qb.size();
      default: return qo.size();
    endcase
  endfunction

  function automatic int q_pop(input int c);
    case (c)
      0:       return qa.pop_front();
      1:       return qb.pop_front();
      default: return qo.pop_front();
    endcase
  endfunction

  function automatic string ch_name(input int c);
    case (c)
      0:       return "boton_a";
      1:       return "boton_b";
      default: return "boton_op";
    endcase
  endfunction

  // Monitor: reset-state outputs and every pulse against the scoreboard.
  always @(negedge clk) begin
    int exp_edge;
    outs = {boton_op, boton_b, boton_a};
    if (rst_edge) begin
      n_checks++;
      if (outs !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_outputs edge %0d: got %b, want 000", edge_n, outs);
      end
    end
    for (int c = 0; c < 3; c++) begin
      if (outs[c] === 1'b1) begin
        n_checks++;
        if (prev_outs[c]) begin
          n_fail++;
          $display("FAIL %s_double edge %0d: high two cycles, want one", ch_name(c), edge_n);
        end else if (q_size(c) == 0) begin
          n_fail++;
          $display("FAIL %s_unexpected edge %0d: got pulse, want none", ch_name(c), edge_n);
        end else begin
          exp_edge = q_pop(c);
          if (exp_edge != edge_n) begin
            n_fail++;
            $display("FAIL %s_timing: got pulse after edge %0d, want edge %0d",
                     ch_name(c), edge_n, exp_edge);
          end
        end
      end
    end
    prev_outs = outs;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int c);
    case (c)
      0:       qa.push_back(edge_n + LAT);
      1:       qb.push_back(edge_n + LAT);
      default: qo.push_back(edge_n + LAT);
    endcase
  endtask

  task automatic chk_cnt(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  initial begin
    boton_a_in  = 1'b1;
    boton_b_in  = 1'b1;
    boton_op_in = 1'b1;
    reset       = 1'b1;
    tick(3);
    // Buttons held through reset release: one pulse per channel.
    reset = 1'b0;
    expect_pulse(0);
    expect_pulse(1);
    expect_pulse(2);
    tick(12);
    boton_a_in  = 1'b0;
    boton_b_in  = 1'b0;
    boton_op_in = 1'b0;
    tick(10);

    // Clean, long press on A: a single pulse.
    boton_a_in = 1'b1;
    expect_pulse(0);
    tick(50);
    boton_a_in = 1'b0;
    tick(10);

    // Bouncing B: pulse only after the final rise is stable.
    boton_b_in = 1'b1; tick(1);
    boton_b_in = 1'b0; tick(1);
    boton_b_in = 1'b1; tick(1);
    boton_b_in = 1'b0; tick(1);
    boton_b_in = 1'b1;
    expect_pulse(1);
    tick(20);
    boton_b_in = 1'b0;
    tick(10);

    // Three-cycle glitch on OP: one cycle short of acceptance.
    boton_op_in = 1'b1;
    tick(3);
    boton_op_in = 1'b0;
    tick(5);
    chk_cnt("op_glitch_cnt", dut.u_canal_op.cnt_r, 3'd0);

    // Re-press after a full debounced release: two pulses.
    boton_a_in = 1'b1;
    expect_pulse(0);
    tick(10);
    boton_a_in = 1'b0;
    tick(10);
    boton_a_in = 1'b1;
    expect_pulse(0);
    tick(10);
    boton_a_in = 1'b0;
    tick(10);

    // Release too short to be accepted: only one pulse.
    boton_a_in = 1'b1;
    expect_pulse(0);
    tick(10);
    boton_a_in = 1'b0;
    tick(3);
    boton_a_in = 1'b1;
    tick(10);
    boton_a_in = 1'b0;
    tick(10);

    // Reset in the middle of a debounce on A.
    boton_a_in = 1'b1;
    tick(4);
    chk_cnt("a_cnt_before_reset", dut.u_canal_a.cnt_r, 3'd2);
    reset = 1'b1;
    tick(1);
    chk_cnt("a_cnt_in_reset", dut.u_canal_a.cnt_r, 3'd0);
    reset = 1'b0;
    expect_pulse(0);
    tick(3);
    chk_cnt("a_cnt_restart", dut.u_canal_a.cnt_r, 3'd1);
    tick(10);
    boton_a_in = 1'b0;
    tick(15);

    // Every scheduled pulse must have been seen.
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (q_size(c) != 0) begin
        n_fail++;
        $display("FAIL %s_missing: got %0d pulses outstanding, want 0", ch_name(c), q_size(c));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
